retospect_cfg_loader: RTL

RETOSPECT_CFG_LOADER -- requirements
Module: retospect_cfg_loader

---
 rtl/retospect_cfg_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/retospect_cfg_loader.sv
// Byte-fed loader for the configuration shift chain.
// It also reads back the previous chain contents and pulses reset_nn once the load is complete.
module retospect_cfg_loader #(
    parameter int unsigned CHAIN_LEN = 498,
    parameter int unsigned NN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       config_en,
    output logic       chain_bs_in,
    input  logic       chain_bs_out,
    output logic       reset_nn,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W   = $clog2(CHAIN_LEN + 1);
    localparam int unsigned NN_W    = (NN_CYCLES > 1) ? $clog2(NN_CYCLES) : 1;
    localparam int unsigned NN_LAST = (NN_CYCLES > 0) ? NN_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_NN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, cnt_inc;
    logic [2:0]       sub_q, sub_d;
    logic [7:0]       sreg_q, sreg_d;
    logic [NN_W-1:0]  nn_cnt_q, nn_cnt_d;
    logic [7:0]       rb_acc_q, rb_acc_d, acc_next;
    logic [7:0]       rb_data_q, rb_data_d;
    logic             rb_valid_q, rb_valid_d;
    logic             last_bit;

    logic byte_ready_q, config_en_q, chain_bs_in_q, reset_nn_q, busy_q, done_q;
    logic byte_ready_d, config_en_d, chain_bs_in_d, reset_nn_d, busy_d, done_d;

    assign cnt_inc  = bit_cnt_q + CNT_W'(1);
    assign last_bit = (cnt_inc == CNT_W'(CHAIN_LEN));

    // Next-state, datapath and output decode; outputs are decoded from the next state and registered
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sub_d      = sub_q;
        sreg_d     = sreg_q;
        nn_cnt_d   = nn_cnt_q;
        rb_acc_d   = rb_acc_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        acc_next   = rb_acc_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_WAIT;
                    bit_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (byte_valid) begin
                    sreg_d  = byte_in;
                    sub_d   = 3'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sreg_d    = {1'b0, sreg_q[7:1]};
                bit_cnt_d = cnt_inc;
                sub_d     = sub_q + 3'd1;
                // Readback bits land at their in-group position so a short final group is zero-padded
                acc_next        = (sub_q == 3'd0) ? 8'h00 : rb_acc_q;
                acc_next[sub_q] = chain_bs_out;
                rb_acc_d        = acc_next;
                if (last_bit || sub_q == 3'd7) begin
                    rb_data_d  = acc_next;
                    rb_valid_d = 1'b1;
                end
                if (last_bit) begin
                    state_d  = S_NN;
                    nn_cnt_d = '0;
                end else if (sub_q == 3'd7) begin
                    state_d = S_WAIT;
                end
            end
            S_NN: begin
                if (nn_cnt_q == NN_W'(NN_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    nn_cnt_d = nn_cnt_q + NN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        byte_ready_d  = (state_d == S_WAIT);
        config_en_d   = (state_d == S_SHIFT);
        chain_bs_in_d = (state_d == S_SHIFT) & sreg_d[0];
        reset_nn_d    = (state_d == S_NN);
        busy_d        = (state_d == S_WAIT) || (state_d == S_SHIFT) || (state_d == S_NN);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            sub_q         <= 3'd0;
            sreg_q        <= 8'h00;
            nn_cnt_q      <= '0;
            rb_acc_q      <= 8'h00;
            rb_data_q     <= 8'h00;
            rb_valid_q    <= 1'b0;
            byte_ready_q  <= 1'b0;
            config_en_q   <= 1'b0;
            chain_bs_in_q <= 1'b0;
            reset_nn_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            sub_q         <= sub_d;
            sreg_q        <= sreg_d;
            nn_cnt_q      <= nn_cnt_d;
            rb_acc_q      <= rb_acc_d;
            rb_data_q     <= rb_data_d;
            rb_valid_q    <= rb_valid_d;
            byte_ready_q  <= byte_ready_d;
            config_en_q   <= config_en_d;
            chain_bs_in_q <= chain_bs_in_d;
            reset_nn_q    <= reset_nn_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign byte_ready  = byte_ready_q;
    assign config_en   = config_en_q;
    assign chain_bs_in = chain_bs_in_q;
    assign reset_nn    = reset_nn_q;
    assign rb_data     = rb_data_q;
    assign rb_valid    = rb_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
